mem_bus_initiator: RTL and testbench

- Bus-side initiator that an accelerator (AES or SHA) uses to talk to the memory command port.
- Takes one transfer request and serialises it onto the shared 8-bit valid/ready bus as 1 command byte plus 3 address bytes (LSB first).
- Then either streams write-result bytes to memory, or collects read bytes and waits for memory's completion ack on the ack bus.
- Completion or error is reported to the owning accelerator.

---
 rtl/mem_bus_initiator_pkg.sv | 46 ++++
 rtl/mem_bus_initiator_skid.sv | 35 +++
 rtl/mem_bus_initiator.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_bus_initiator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_initiator_pkg.sv
// Protocol constants shared by the accelerator-side memory bus initiator:
// unit IDs, transfer opcodes and the command byte layout.
package mem_bus_initiator_pkg;

  localparam logic [1:0] MEM_ID = 2'b00;
  localparam logic [1:0] SHA_ID = 2'b01;
  localparam logic [1:0] AES_ID = 2'b10;

  typedef enum logic [1:0] {
    OP_RD_KEY  = 2'b00,
    OP_RD_TEXT = 2'b01,
    OP_WR_RES  = 2'b10,
    OP_OTHER   = 2'b11
  } opcode_e;

  localparam int CMD_ENC_BIT  = 7;
  localparam int CMD_DEST_LSB = 4;
  localparam int CMD_SRC_LSB  = 2;
  localparam int CMD_OP_LSB   = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic        enc;
    logic [23:0] addr;
  } req_t;

  // Reads are addressed from the accelerator to memory; write results are
  // framed as if memory were sending to the accelerator.
  function automatic logic [7:0] build_cmd(input logic [1:0] op,
                                           input logic       enc,
                                           input logic [1:0] own);
    logic [7:0] cmd;
    cmd = '0;
    cmd[CMD_ENC_BIT] = enc;
    if (op == OP_WR_RES) begin
      cmd[CMD_DEST_LSB +: 2] = own;
      cmd[CMD_SRC_LSB +: 2]  = MEM_ID;
    end else begin
      cmd[CMD_DEST_LSB +: 2] = MEM_ID;
      cmd[CMD_SRC_LSB +: 2]  = own;
    end
    cmd[CMD_OP_LSB +: 2] = op;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_bus_initiator_skid.sv
// One-entry valid/ready output register; a new word may replace the held
// word in the same cycle it is taken, so back-to-back streaming has no gaps.
module byte_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_valid && in_ready) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// Serialises one accelerator transfer request onto the shared byte bus
// (command + 3 address bytes), then streams write data or collects read data.
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter logic [1:0] OWN_ID      = 2'b10,
  parameter int         LEN_W       = 8,
  parameter int         ACK_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_req_valid,
  output logic             out_req_ready,
  input  logic [1:0]       in_req_opcode,
  input  logic             in_req_enc_type,
  input  logic [23:0]      in_req_addr,
  input  logic [LEN_W-1:0] in_req_len,
  output logic             out_bus_valid,
  output logic [7:0]       out_bus_data,
  input  logic             in_bus_ready,
  input  logic             in_bus_valid,
  input  logic [7:0]       in_bus_data,
  output logic             out_bus_ready,
  input  logic             in_wr_valid,
  input  logic [7:0]       in_wr_data,
  output logic             out_wr_ready,
  output logic             out_rd_valid,
  output logic [7:0]       out_rd_data,
  input  logic             in_rd_ready,
  input  logic             in_ack_valid,
  input  logic [1:0]       in_ack_id,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD      = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_DATA_WR  = 3'd3;
  localparam logic [2:0] ST_DATA_RD  = 3'd4;
  localparam logic [2:0] ST_WAIT_ACK = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  logic [2:0]       state_reg, state_next;
  logic             run_reg;
  req_t             req_reg;
  logic [LEN_W-1:0] len_reg;
  logic [1:0]       addr_cnt_reg, addr_cnt_next;
  logic [LEN_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             ack_reg, ack_next;
  logic             err_reg, err_next;

  logic             req_fire;
  logic             bus_load;
  logic [7:0]       bus_load_data;
  logic             bus_load_ready;
  logic             rd_load_ready;
  logic             rd_fire;
  logic             wr_fire;
  logic             byte_left;
  logic             ack_live;
  logic             ack_seen;
  logic             drained;
  logic [LEN_W-1:0] byte_cnt_inc;
  logic [LEN_W-1:0] rd_cnt_after;

  // Ready is held low until the first clock after reset release so that
  // every output reads 0 while reset is asserted.
  assign out_req_ready = (state_reg == ST_IDLE) && run_reg;
  assign req_fire      = in_req_valid && out_req_ready;
  assign out_busy      = (state_reg != ST_IDLE);

  assign byte_left    = (byte_cnt_reg < len_reg);
  assign byte_cnt_inc = byte_cnt_reg + LEN_W'(1);
  assign ack_live     = in_ack_valid && (in_ack_id == MEM_ID);
  assign ack_seen     = ack_reg || ack_live;

  assign out_wr_ready  = (state_reg == ST_DATA_WR) && bus_load_ready && byte_left;
  assign wr_fire       = in_wr_valid && out_wr_ready;
  assign out_bus_ready = (state_reg == ST_DATA_RD) && rd_load_ready && byte_left;
  assign rd_fire       = in_bus_valid && out_bus_ready;
  assign rd_cnt_after  = rd_fire ? byte_cnt_inc : byte_cnt_reg;

  assign drained  = !out_rd_valid && !out_bus_valid;
  assign out_done = (state_reg == ST_DONE) && drained;
  assign out_err  = out_done && err_reg;

  byte_skid_reg #(.W(8)) u_bus_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus_load),
    .in_data   (bus_load_data),
    .in_ready  (bus_load_ready),
    .out_valid (out_bus_valid),
    .out_data  (out_bus_data),
    .out_ready (in_bus_ready)
  );

  byte_skid_reg #(.W(8)) u_rd_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (in_bus_data),
    .in_ready  (rd_load_ready),
    .out_valid (out_rd_valid),
    .out_data  (out_rd_data),
    .out_ready (in_rd_ready)
  );

  always_comb begin
    state_next    = state_reg;
    addr_cnt_next = addr_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    ack_next      = ack_reg;
    err_next      = err_reg;
    bus_load      = 1'b0;
    bus_load_data = in_wr_data;

    if (((state_reg == ST_DATA_RD) || (state_reg == ST_WAIT_ACK)) && ack_live) begin
      ack_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (req_fire) begin
          if (in_req_opcode == OP_OTHER) begin
            state_next = ST_DONE;
            err_next   = 1'b1;
          end else begin
            state_next = ST_CMD;
          end
        end
      end

      ST_CMD: begin
        bus_load      = bus_load_ready;
        bus_load_data = build_cmd(req_reg.op, req_reg.enc, OWN_ID);
        if (bus_load_ready) begin
          state_next    = ST_ADDR;
          addr_cnt_next = 2'd0;
        end
      end

      ST_ADDR: begin
        bus_load = bus_load_ready;
        case (addr_cnt_reg)
          2'd0:    bus_load_data = req_reg.addr[7:0];
          2'd1:    bus_load_data = req_reg.addr[15:8];
          default: bus_load_data = req_reg.addr[23:16];
        endcase
        if (bus_load_ready) begin
          if (addr_cnt_reg == 2'd2) begin
            byte_cnt_next = '0;
            tmo_cnt_next  = '0;
            if (req_reg.op == OP_WR_RES) begin
              state_next = (len_reg == '0) ? ST_DONE : ST_DATA_WR;
            end else begin
              state_next = (len_reg == '0) ? ST_WAIT_ACK : ST_DATA_RD;
            end
          end else begin
            addr_cnt_next = addr_cnt_reg + 2'd1;
          end
        end
      end

      ST_DATA_WR: begin
        bus_load      = wr_fire;
        bus_load_data = in_wr_data;
        if (wr_fire) begin
          byte_cnt_next = byte_cnt_inc;
          if (byte_cnt_inc == len_reg) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DATA_RD: begin
        byte_cnt_next = rd_cnt_after;
        // An ack alongside the final byte is a clean finish; earlier is short.
        if (rd_cnt_after == len_reg) begin
          state_next = ack_seen ? ST_DONE : ST_WAIT_ACK;
        end else if (ack_seen) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        if (ack_seen) begin
          state_next = ST_DONE;
        end else if ((ACK_TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST)) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end

      ST_DONE: begin
        if (drained) begin
          state_next    = ST_IDLE;
          ack_next      = 1'b0;
          err_next      = 1'b0;
          byte_cnt_next = '0;
          addr_cnt_next = 2'd0;
          tmo_cnt_next  = '0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      run_reg      <= 1'b0;
      req_reg      <= '0;
      len_reg      <= '0;
      addr_cnt_reg <= 2'd0;
      byte_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_reg      <= 1'b1;
      addr_cnt_reg <= addr_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      if (req_fire) begin
        req_reg.op   <= in_req_opcode;
        req_reg.enc  <= in_req_enc_type;
        req_reg.addr <= in_req_addr;
        len_reg      <= in_req_len;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator: a table of whole transfers plus a
// reset-during-write sequence.
module tb_mem_bus_initiator;
  import mem_bus_initiator_pkg::*;

  localparam int LEN_W = 8;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_req_valid;
  logic             out_req_ready;
  logic [1:0]       in_req_opcode;
  logic             in_req_enc_type;
  logic [23:0]      in_req_addr;
  logic [LEN_W-1:0] in_req_len;
  logic             out_bus_valid;
  logic [7:0]       out_bus_data;
  logic             in_bus_ready;
  logic             in_bus_valid;
  logic [7:0]       in_bus_data;
  logic             out_bus_ready;
  logic             in_wr_valid;
  logic [7:0]       in_wr_data;
  logic             out_wr_ready;
  logic             out_rd_valid;
  logic [7:0]       out_rd_data;
  logic             in_rd_ready;
  logic             in_ack_valid;
  logic [1:0]       in_ack_id;
  logic             out_busy;
  logic             out_done;
  logic             out_err;

  always #5 clk = ~clk;

  mem_bus_initiator #(.OWN_ID(2'b10), .LEN_W(LEN_W), .ACK_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_req_valid    (in_req_valid),
    .out_req_ready   (out_req_ready),
    .in_req_opcode   (in_req_opcode),
    .in_req_enc_type (in_req_enc_type),
    .in_req_addr     (in_req_addr),
    .in_req_len      (in_req_len),
    .out_bus_valid   (out_bus_valid),
    .out_bus_data    (out_bus_data),
    .in_bus_ready    (in_bus_ready),
    .in_bus_valid    (in_bus_valid),
    .in_bus_data     (in_bus_data),
    .out_bus_ready   (out_bus_ready),
    .in_wr_valid     (in_wr_valid),
    .in_wr_data      (in_wr_data),
    .out_wr_ready    (out_wr_ready),
    .out_rd_valid    (out_rd_valid),
    .out_rd_data     (out_rd_data),
    .in_rd_ready     (in_rd_ready),
    .in_ack_valid    (in_ack_valid),
    .in_ack_id       (in_ack_id),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_err         (out_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] all_outputs();
    return {out_req_ready, out_bus_valid, out_bus_data, out_bus_ready, out_wr_ready,
            out_rd_valid, out_rd_data, out_busy, out_done, out_err};
  endfunction

  task automatic idle_inputs();
    in_req_valid = 1'b0; in_req_opcode = 2'b00; in_req_enc_type = 1'b0;
    in_req_addr = 24'h0; in_req_len = '0;
    in_bus_ready = 1'b0; in_bus_valid = 1'b0; in_bus_data = 8'h00;
    in_wr_valid = 1'b0; in_wr_data = 8'h00; in_rd_ready = 1'b0;
    in_ack_valid = 1'b0; in_ack_id = 2'b00;
  endtask

  // ack_mode: 0 none, 1 ack after all bytes, 2 ack after 2 bytes, 3 foreign ack then timeout
  typedef struct {
    logic [1:0]  op;
    logic        enc;
    logic [23:0] addr;
    int          len;
    int          ack_mode;
    bit          bus_tgl;
    bit          rd_tgl;
    logic [7:0]  exp_cmd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_txn(input int t, input vec_t v);
    logic [7:0] wdata[$];
    logic [7:0] rdata[$];
    logic [7:0] exp_bus[$];
    logic [7:0] got_bus[$];
    logic [7:0] got_rd[$];
    int  feed_limit;
    int  wr_idx = 0, feed_idx = 0, done_cnt = 0, cyc = 0, stray_err = 0;
    int  accept_cyc = -1, last_feed_cyc = -1, done_cyc = -1;
    bit  req_pend = 1'b1, ack_sent = 1'b0, err_seen = 1'b0;
    bit  is_wr, is_rd;
    int  nb, nr;

    is_wr = (v.op == OP_WR_RES);
    is_rd = (v.op == OP_RD_KEY) || (v.op == OP_RD_TEXT);
    for (int i = 0; i < v.len; i++) begin
      wdata.push_back(8'(8'hC0 + t * 16 + i));
      rdata.push_back(8'(8'h30 + i * 7 + t));
    end
    feed_limit = is_rd ? ((v.ack_mode == 2) ? 2 : v.len) : 0;
    if (v.op != OP_OTHER) begin
      exp_bus.push_back(v.exp_cmd);
      exp_bus.push_back(v.addr[7:0]);
      exp_bus.push_back(v.addr[15:8]);
      exp_bus.push_back(v.addr[23:16]);
      if (is_wr) foreach (wdata[i]) exp_bus.push_back(wdata[i]);
    end

    in_req_opcode   = v.op;
    in_req_enc_type = v.enc;
    in_req_addr     = v.addr;
    in_req_len      = LEN_W'(v.len);

    while (cyc < 300 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
      @(posedge clk); #1;
      in_req_valid = req_pend;
      in_bus_ready = v.bus_tgl ? cyc[0] : 1'b1;
      in_rd_ready  = v.rd_tgl ? (cyc % 3 != 0) : 1'b1;
      in_wr_valid  = is_wr && (wr_idx < v.len);
      in_wr_data   = in_wr_valid ? wdata[wr_idx] : 8'h00;
      in_bus_valid = is_rd && (feed_idx < feed_limit);
      in_bus_data  = in_bus_valid ? rdata[feed_idx] : 8'h00;
      in_ack_valid = 1'b0;
      in_ack_id    = MEM_ID;
      if (is_rd && v.ack_mode != 0 && !ack_sent && feed_idx == feed_limit && got_bus.size() >= 4) begin
        in_ack_valid = 1'b1;
        in_ack_id    = (v.ack_mode == 3) ? SHA_ID : MEM_ID;
        ack_sent     = 1'b1;
      end
      #1;
      if (in_req_valid && out_req_ready) begin req_pend = 1'b0; accept_cyc = cyc; end
      if (out_bus_valid && in_bus_ready) got_bus.push_back(out_bus_data);
      if (in_wr_valid && out_wr_ready) wr_idx++;
      if (in_bus_valid && out_bus_ready) begin
        feed_idx++;
        if (feed_idx == feed_limit) last_feed_cyc = cyc;
      end
      if (out_rd_valid && in_rd_ready) got_rd.push_back(out_rd_data);
      if (out_done) begin done_cnt++; done_cyc = cyc; err_seen = out_err; end
      if (out_err && !out_done) stray_err++;
      cyc++;
    end

    check($sformatf("t%0d done_count", t), done_cnt, 1);
    check($sformatf("t%0d err", t), 32'(err_seen), 32'(v.exp_err));
    check($sformatf("t%0d stray_err", t), stray_err, 0);
    check($sformatf("t%0d bus_bytes", t), got_bus.size(), exp_bus.size());
    nb = (got_bus.size() < exp_bus.size()) ? got_bus.size() : exp_bus.size();
    for (int i = 0; i < nb; i++)
      check($sformatf("t%0d bus[%0d]", t, i), got_bus[i], exp_bus[i]);
    check($sformatf("t%0d rd_bytes", t), got_rd.size(), feed_limit);
    nr = (got_rd.size() < feed_limit) ? got_rd.size() : feed_limit;
    for (int i = 0; i < nr; i++)
      check($sformatf("t%0d rd[%0d]", t, i), got_rd[i], rdata[i]);
    if (v.op == OP_OTHER)
      check($sformatf("t%0d other_latency", t), done_cyc - accept_cyc, 1);
    if (v.ack_mode == 3)
      check($sformatf("t%0d timeout_latency", t), done_cyc - last_feed_cyc, TMO + 1);
    $display("txn %0d op=%0d addr=%06h len=%0d bus=%0d rd=%0d done=%0d err=%0d",
             t, v.op, v.addr, v.len, got_bus.size(), got_rd.size(), done_cnt, err_seen);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pend;
    int reached;

    vecs[0] = '{op: OP_RD_KEY,  enc: 1'b0, addr: 24'h123456, len: 4, ack_mode: 1, bus_tgl: 1'b0, rd_tgl: 1'b0, exp_cmd: 8'h08, exp_err: 1'b0};
    vecs[1] = '{op: OP_WR_RES,  enc: 1'b1, addr: 24'hABCDEF, len: 3, ack_mode: 0, bus_tgl: 1'b1, rd_tgl: 1'b0, exp_cmd: 8'hA2, exp_err: 1'b0};
    vecs[2] = '{op: OP_RD_TEXT, enc: 1'b0, addr: 24'h000102, len: 4, ack_mode: 2, bus_tgl: 1'b0, rd_tgl: 1'b0, exp_cmd: 8'h09, exp_err: 1'b1};
    vecs[3] = '{op: OP_RD_KEY,  enc: 1'b1, addr: 24'h00FF00, len: 2, ack_mode: 3, bus_tgl: 1'b0, rd_tgl: 1'b0, exp_cmd: 8'h88, exp_err: 1'b1};
    vecs[4] = '{op: OP_OTHER,   enc: 1'b0, addr: 24'h111111, len: 5, ack_mode: 0, bus_tgl: 1'b0, rd_tgl: 1'b0, exp_cmd: 8'h00, exp_err: 1'b1};
    vecs[5] = '{op: OP_WR_RES,  enc: 1'b0, addr: 24'h445566, len: 0, ack_mode: 0, bus_tgl: 1'b0, rd_tgl: 1'b0, exp_cmd: 8'h22, exp_err: 1'b0};
    vecs[6] = '{op: OP_RD_TEXT, enc: 1'b0, addr: 24'h7890AB, len: 0, ack_mode: 1, bus_tgl: 1'b0, rd_tgl: 1'b0, exp_cmd: 8'h09, exp_err: 1'b0};
    vecs[7] = '{op: OP_RD_KEY,  enc: 1'b1, addr: 24'hFEDCBA, len: 5, ack_mode: 1, bus_tgl: 1'b1, rd_tgl: 1'b1, exp_cmd: 8'h88, exp_err: 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset outputs", 32'(all_outputs()), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset req_ready", 32'(out_req_ready), 32'h1);
    check("post-reset busy", 32'(out_busy), 32'h0);

    for (int t = 0; t < 8; t++) run_txn(t, vecs[t]);

    // Reset asserted while the initiator is waiting for write data.
    in_req_opcode = OP_WR_RES; in_req_enc_type = 1'b1;
    in_req_addr = 24'h0A0B0C; in_req_len = LEN_W'(3);
    in_bus_ready = 1'b1;
    pend = 1; reached = 0;
    for (int c = 0; c < 20 && reached == 0; c++) begin
      @(posedge clk); #1;
      in_req_valid = (pend != 0);
      #1;
      if (in_req_valid && out_req_ready) pend = 0;
      if (out_wr_ready) reached = 1;
    end
    check("reach DATA_WR", reached, 1);
    in_req_valid = 1'b0;
    in_wr_valid = 1'b1; in_wr_data = 8'h77;
    #1 rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(all_outputs()), 32'h0);
    idle_inputs();
    @(posedge clk); #1;
    check("held reset outputs", 32'(all_outputs()), 32'h0);
    rst_n = 1'b1;
    $display("reset during DATA_WR applied and released");
    run_txn(8, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
